core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle sequencer for the RV32I integer core. It fetches each instruction over a valid/ready instruction-memory port and holds it stable for the combinational instruction decoder. It then steps the register-file read, ALU execute and writeback phases, and advances the PC. An instruction the decoder flags as invalid traps the core.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clocking and reset: one clock, `clk_in`; reset `rst_n_in` is asynchronous and active-low.
- clk_in  input  1  core clock.
- rst_n_in  input  1  asynchronous active-low reset.
- hold_in  input  1  when 1, blocks the start of a new fetch.
- imem_req_out  output  1  fetch request (valid).
- imem_addr_out  output  32  fetch address; equals pc_out.
- imem_ready_in  input  1  memory accepts the request; imem_rdata_in is valid in the same cycle.
- imem_rdata_in  input  32  fetched instruction word.
- instr_out  output  32  latched instruction, driven to the decoder.
- dec_valid_in  input  1  decoder: instruction is legal.
- dec_rs1_read_in  input  1  decoder: instruction reads rs1.
- dec_rs2_read_in  input  1  decoder: instruction reads rs2.
- dec_rd_write_in  input  1  decoder: instruction writes rd.
- rf_rd_en_out  output  1  register-file read enable.
- alu_result_in  input  32  ALU result.
- rf_wr_en_out  output  1  register-file write enable.
- rf_waddr_out  output  5  write address, instr_out[11:7].
- rf_wdata_out  output  32  write data, from the registered ALU result.
- pc_out  output  32  address of the current instruction.
- retire_out  output  1  one-cycle pulse per retired instruction.
- retire_count_out  output  32  count of retired instructions.
- illegal_out  output  1  level; 1 while in TRAP.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE
  - imem_req_out=0.
  - Goes to FETCH when hold_in=0; otherwise stays.
- FETCH
  - imem_req_out=1, imem_addr_out=pc_out.
  - On imem_ready_in=1: latch imem_rdata_in into instr_out, go to DECODE.
  - Otherwise stay. Request and address stay stable until accepted; hold_in is ignored here.
- DECODE
  - If dec_valid_in=0: go to TRAP.
  - Otherwise: rf_rd_en_out = dec_rs1_read_in | dec_rs2_read_in, go to EXECUTE.
- EXECUTE
  - Register alu_result_in into the result register.
  - Go to WRITEBACK.
- WRITEBACK
  - rf_wr_en_out = dec_rd_write_in & (instr_out[11:7] != 0); writes to x0 are suppressed.
  - retire_out=1.
  - pc_out <= pc_out + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - retire_count_out increments, wrapping 32'hFFFF_FFFF to 0.
  - Next state: FETCH if hold_in=0, else IDLE.
- TRAP
  - illegal_out=1, no fetch requests.
  - pc_out holds the address of the offending instruction; instr_out holds the offending word.
  - Left only by reset.
- instr_out changes only on FETCH acceptance, so decoder outputs stay stable from DECODE through WRITEBACK.

## Timing
- Reset (asynchronous assert)
  - State = IDLE, pc_out=RESET_PC, instr_out=0, retire_count_out=0, result register=0.
  - imem_req_out, rf_rd_en_out, rf_wr_en_out, retire_out, illegal_out all 0.
- Reset deassertion: the first FETCH cycle is the cycle after the first IDLE cycle with hold_in=0.
- Reset mid-operation: an outstanding fetch is abandoned and no writeback occurs.
- Latency: 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK) when imem_ready_in is 1 in the first FETCH cycle. Each wait cycle adds 1.
- Back-to-back instructions: FETCH follows WRITEBACK directly, with no idle cycle, when hold_in=0.
- Output types:
  - rf_rd_en_out, rf_wr_en_out, retire_out, imem_req_out and illegal_out are decoded from the registered state.
  - rf_waddr_out and rf_wdata_out are registered or derived from registered values.
- hold_in is sampled only in IDLE and WRITEBACK.

## Test plan
- Reset then release with hold_in=0:
  - While in reset: pc_out=0, all strobes 0, retire_count_out=0.
  - imem_req_out=1 in the 2nd cycle after release.
- Fetch 32'h0050_0093 (ADDI x1,x0,5); imem_ready_in=1 immediately; alu_result_in=5, dec_valid/rs1/rd=1:
  - Cycle 4: rf_wr_en_out=1, rf_waddr_out=1, rf_wdata_out=5, retire_out=1.
  - Afterwards: pc_out=4, retire_count_out=1.
- imem_ready_in delayed 3 cycles:
  - imem_req_out and imem_addr_out are stable for 4 cycles.
  - The write occurs in cycle 7.
- 32'h0000_0013 (NOP, rd=x0): rf_wr_en_out stays 0, retire_out pulses, pc advances by 4.
- 32'hFFFF_FFFF with dec_valid_in=0:
  - illegal_out=1 from the cycle after DECODE; no further imem_req_out.
  - pc_out unchanged until rst_n_in is asserted.
- Hold, wrap and reset cases:
  - RESET_PC=32'hFFFF_FFFC with hold_in=1 during WRITEBACK: state goes to IDLE, pc_out=0, no request; releasing hold_in resumes FETCH at address 0.
  - Asserting rst_n_in during FETCH: imem_req_out drops immediately.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for an RV32I core.
// Holds each fetched word stable for the external decoder and advances the PC on retirement.
module core_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        hold_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ready_in,
   input  logic [31:0] imem_rdata_in,
   output logic [31:0] instr_out,
   input  logic        dec_valid_in,
   input  logic        dec_rs1_read_in,
   input  logic        dec_rs2_read_in,
   input  logic        dec_rd_write_in,
   output logic        rf_rd_en_out,
   input  logic [31:0] alu_result_in,
   output logic        rf_wr_en_out,
   output logic [4:0]  rf_waddr_out,
   output logic [31:0] rf_wdata_out,
   output logic [31:0] pc_out,
   output logic        retire_out,
   output logic [31:0] retire_count_out,
   output logic        illegal_out
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_result;
   logic [31:0] r_retire_cnt;
   logic        w_rd_is_x0;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_instr      <= 32'h0;
         r_result     <= 32'h0;
         r_retire_cnt <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!hold_in) r_state <= S_FETCH;
            end
            S_FETCH: begin
               // Only acceptance may change the word the decoder is looking at.
               if (imem_ready_in) begin
                  r_instr <= imem_rdata_in;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= dec_valid_in ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
               r_result <= alu_result_in;
               r_state  <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               r_pc         <= r_pc + 32'd4;
               r_retire_cnt <= r_retire_cnt + 32'd1;
               r_state      <= hold_in ? S_IDLE : S_FETCH;
            end
            S_TRAP: begin
               r_state <= S_TRAP;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_rd_is_x0 = (r_instr[11:7] == 5'd0);

   // Strobes are pure decodes of the state register, so reset clears them at once.
   assign imem_req_out     = (r_state == S_FETCH);
   assign imem_addr_out    = r_pc;
   assign instr_out        = r_instr;
   assign rf_rd_en_out     = (r_state == S_DECODE) && dec_valid_in
                             && (dec_rs1_read_in || dec_rs2_read_in);
   assign rf_wr_en_out     = (r_state == S_WRITEBACK) && dec_rd_write_in && !w_rd_is_x0;
   assign rf_waddr_out     = r_instr[11:7];
   assign rf_wdata_out     = r_result;
   assign pc_out           = r_pc;
   assign retire_out       = (r_state == S_WRITEBACK);
   assign retire_count_out = r_retire_cnt;
   assign illegal_out      = (r_state == S_TRAP);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: expected writebacks are queued at fetch and checked at retirement.
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst2_n = 1'b0;
   logic        hold = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        dec_valid = 1'b1;
   logic        dec_rs1 = 1'b0;
   logic        dec_rs2 = 1'b0;
   logic        dec_rd = 1'b0;
   logic [31:0] alu_result = 32'h0;

   logic        req, rd_en, wr_en, retire, illegal;
   logic [31:0] addr, instr_o, wdata, pc, rcnt;
   logic [4:0]  waddr;
   logic        req2, rd_en2, wr_en2, retire2, illegal2;
   logic [31:0] addr2, instr2, wdata2, pc2, rcnt2;
   logic [4:0]  waddr2;

   typedef struct packed {
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] exp_cnt = 32'h0;

   always #5 clk = ~clk;

   core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .hold_in(hold),
      .imem_req_out(req), .imem_addr_out(addr), .imem_ready_in(imem_ready),
      .imem_rdata_in(imem_rdata), .instr_out(instr_o),
      .dec_valid_in(dec_valid), .dec_rs1_read_in(dec_rs1), .dec_rs2_read_in(dec_rs2),
      .dec_rd_write_in(dec_rd), .rf_rd_en_out(rd_en), .alu_result_in(alu_result),
      .rf_wr_en_out(wr_en), .rf_waddr_out(waddr), .rf_wdata_out(wdata),
      .pc_out(pc), .retire_out(retire), .retire_count_out(rcnt), .illegal_out(illegal)
   );

   core_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_in(clk), .rst_n_in(rst2_n), .hold_in(hold),
      .imem_req_out(req2), .imem_addr_out(addr2), .imem_ready_in(imem_ready),
      .imem_rdata_in(imem_rdata), .instr_out(instr2),
      .dec_valid_in(dec_valid), .dec_rs1_read_in(dec_rs1), .dec_rs2_read_in(dec_rs2),
      .dec_rd_write_in(dec_rd), .rf_rd_en_out(rd_en2), .alu_result_in(alu_result),
      .rf_wr_en_out(wr_en2), .rf_waddr_out(waddr2), .rf_wdata_out(wdata2),
      .pc_out(pc2), .retire_out(retire2), .retire_count_out(rcnt2), .illegal_out(illegal2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_exp(output exp_t e);
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL sb_empty: observed=0 entries expected>=1");
      end
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
   endtask

   // Entered in the first FETCH cycle of the main DUT; leaves in the next FETCH cycle.
   task automatic run_instr(input string nm, input logic [31:0] ins, input logic [31:0] alu,
                            input logic r1, input logic r2, input logic rd, input int dly);
      exp_t e;
      imem_rdata = ins;
      alu_result = alu;
      dec_valid  = 1'b1;
      dec_rs1    = r1;
      dec_rs2    = r2;
      dec_rd     = rd;
      imem_ready = (dly == 0);
      chk({nm, "_req"}, 32'(req), 32'd1);
      chk({nm, "_addr"}, addr, exp_pc);
      for (int k = 1; k <= dly; k++) begin
         step();
         chk({nm, "_req_wait"}, 32'(req), 32'd1);
         chk({nm, "_addr_wait"}, addr, exp_pc);
         imem_ready = (k == dly);
      end
      e.wr = rd && (ins[11:7] != 5'd0);
      e.wa = ins[11:7];
      e.wd = alu;
      sb.push_back(e);
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'h0BAD_F00D;
      #1;
      chk({nm, "_instr"}, instr_o, ins);
      chk({nm, "_rd_en"}, 32'(rd_en), 32'(r1 | r2));
      chk({nm, "_req_dec"}, 32'(req), 32'd0);
      step();
      chk({nm, "_retire_ex"}, 32'(retire), 32'd0);
      step();
      alu_result = ~alu;
      #1;
      pop_exp(e);
      chk({nm, "_wr_en"}, 32'(wr_en), 32'(e.wr));
      chk({nm, "_waddr"}, 32'(waddr), 32'(e.wa));
      chk({nm, "_wdata"}, wdata, e.wd);
      chk({nm, "_retire"}, 32'(retire), 32'd1);
      step();
      exp_pc  = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
      chk({nm, "_pc_next"}, pc, exp_pc);
      chk({nm, "_rcnt"}, rcnt, exp_cnt);
      chk({nm, "_retire_off"}, 32'(retire), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      // Reset state
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_rcnt", rcnt, 32'h0);
      chk("rst_instr", instr_o, 32'h0);

      // Release: IDLE in cycle 1, FETCH in cycle 2
      step();
      rst_n = 1'b1;
      hold  = 1'b0;
      #1;
      chk("rel_c1_req", 32'(req), 32'd0);
      step();
      chk("rel_c2_req", 32'(req), 32'd1);

      run_instr("addi", 32'h0050_0093, 32'd5, 1'b1, 1'b0, 1'b1, 0);
      run_instr("wait3", 32'h00A0_0113, 32'd10, 1'b1, 1'b0, 1'b1, 3);
      run_instr("nop", 32'h0000_0013, 32'h0000_DEAD, 1'b1, 1'b0, 1'b1, 0);
      run_instr("add", 32'h0020_81B3, 32'd15, 1'b1, 1'b1, 1'b1, 1);

      // Illegal instruction traps and stops fetching
      imem_rdata = 32'hFFFF_FFFF;
      dec_valid  = 1'b0;
      imem_ready = 1'b1;
      chk("ill_req", 32'(req), 32'd1);
      step();
      chk("ill_dec_instr", instr_o, 32'hFFFF_FFFF);
      chk("ill_dec_flag", 32'(illegal), 32'd0);
      chk("ill_dec_rd_en", 32'(rd_en), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("trap_illegal", 32'(illegal), 32'd1);
         chk("trap_req", 32'(req), 32'd0);
         chk("trap_pc", pc, exp_pc);
         chk("trap_retire", 32'(retire), 32'd0);
      end
      chk("trap_instr", instr_o, 32'hFFFF_FFFF);
      chk("trap_rcnt", rcnt, exp_cnt);
      imem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("trap_rst_illegal", 32'(illegal), 32'd0);
      chk("trap_rst_pc", pc, 32'h0);

      // PC wrap with hold during writeback
      step();
      rst2_n     = 1'b1;
      hold       = 1'b0;
      dec_valid  = 1'b1;
      dec_rs1    = 1'b1;
      dec_rs2    = 1'b0;
      dec_rd     = 1'b1;
      imem_rdata = 32'h0050_0093;
      alu_result = 32'd7;
      imem_ready = 1'b1;
      #1;
      chk("w_idle_req", 32'(req2), 32'd0);
      chk("w_rst_pc", pc2, 32'hFFFF_FFFC);
      step();
      chk("w_fetch_req", 32'(req2), 32'd1);
      chk("w_fetch_addr", addr2, 32'hFFFF_FFFC);
      e.wr = 1'b1;
      e.wa = 5'd1;
      e.wd = 32'd7;
      sb.push_back(e);
      step();
      imem_ready = 1'b0;
      step();
      hold = 1'b1;
      step();
      alu_result = 32'd99;
      #1;
      pop_exp(e);
      chk("w_wr_en", 32'(wr_en2), 32'(e.wr));
      chk("w_waddr", 32'(waddr2), 32'(e.wa));
      chk("w_wdata", wdata2, e.wd);
      chk("w_retire", 32'(retire2), 32'd1);
      step();
      chk("w_wrap_pc", pc2, 32'h0);
      chk("w_rcnt", rcnt2, 32'd1);
      chk("w_retire_off", 32'(retire2), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("w_hold_req", 32'(req2), 32'd0);
      end
      hold = 1'b0;
      step();
      chk("w_resume_req", 32'(req2), 32'd1);
      chk("w_resume_addr", addr2, 32'h0);

      // Reset during an outstanding fetch
      step();
      chk("w_fetch_stall", 32'(req2), 32'd1);
      #2;
      rst2_n = 1'b0;
      #1;
      chk("w_rst_req", 32'(req2), 32'd0);
      chk("w_rst_pc2", pc2, 32'hFFFF_FFFC);
      chk("w_rst_rcnt", rcnt2, 32'h0);
      chk("w_rst_instr", instr2, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("w_rst_retire", 32'(retire2), 32'd0);
         chk("w_rst_wr_en", 32'(wr_en2), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
